// File: rtl/axis_frame_peak_if.sv
// AXI-Stream bundle (data, valid, last, ready) shared by the summary stage's
// input magnitude stream and its output summary stream.
interface axis_frame_peak_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_frame_peak.sv
// Per-frame magnitude statistics: accumulates sum, peak and peak position over
// each frame and emits one 128-bit summary beat when the frame closes.
module axis_frame_peak #(
    parameter int FRAME_LEN = 4096,
    parameter int MAG_LSB   = 40,
    parameter int MAG_W     = 24
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_areset,
    axis_frame_peak_if.slave      s00_axis,
    axis_frame_peak_if.master     m00_axis
);
    localparam int LOG2_LEN = $clog2(FRAME_LEN);
    localparam int CNT_W    = LOG2_LEN + 1;
    localparam int SUM_W    = MAG_W + LOG2_LEN;

    typedef enum logic {EMPTY, FULL} out_state_t;

    out_state_t         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [SUM_W-1:0]   sum_reg;
    logic [MAG_W-1:0]   peak_reg;
    logic [15:0]        pidx_reg;
    logic [15:0]        seq_reg;
    logic [127:0]       m_tdata_reg;
    logic               m_tvalid_reg;

    logic [MAG_W-1:0]   mag;
    logic               at_len;
    logic               closing;
    logic               accept;
    logic               frame_close;
    logic               take;
    logic [CNT_W-1:0]   cnt_next;
    logic [SUM_W-1:0]   sum_next;
    logic [MAG_W-1:0]   peak_next;
    logic [15:0]        pidx_next;
    logic [127:0]       summary_next;
    logic               unused_tdata;

    assign mag          = s00_axis.tdata[MAG_LSB +: MAG_W];
    assign unused_tdata = ^s00_axis.tdata;

    assign at_len  = (cnt_reg == CNT_W'(FRAME_LEN - 1));
    assign closing = s00_axis.tlast || at_len;

    // Only a closing beat can collide with a pending summary, so only it stalls.
    assign s00_axis.tready = !s00_axis_areset &&
                             !((state_reg == FULL) && !m00_axis.tready && closing);

    assign accept      = s00_axis.tvalid && s00_axis.tready;
    assign frame_close = accept && closing;

    // First beat always seeds the peak; strict compare keeps the earliest tie.
    assign take      = (cnt_reg == '0) || (mag > peak_reg);
    assign cnt_next  = cnt_reg + CNT_W'(1);
    assign sum_next  = sum_reg + SUM_W'(mag);
    assign peak_next = take ? mag : peak_reg;
    assign pidx_next = take ? 16'(cnt_reg) : pidx_reg;

    always_comb begin
        summary_next          = '0;
        summary_next[127:80]  = 48'(sum_next);
        summary_next[79:56]   = 24'(peak_next);
        summary_next[55:40]   = pidx_next;
        summary_next[39:24]   = 16'(cnt_next);
        summary_next[23:8]    = seq_reg;
        summary_next[1]       = at_len && !s00_axis.tlast;
        summary_next[0]       = s00_axis.tlast && !at_len;
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state_reg    <= EMPTY;
            m_tvalid_reg <= 1'b0;
            m_tdata_reg  <= '0;
            cnt_reg      <= '0;
            sum_reg      <= '0;
            peak_reg     <= '0;
            pidx_reg     <= '0;
            seq_reg      <= '0;
        end else begin
            if (accept) begin
                if (closing) begin
                    cnt_reg  <= '0;
                    sum_reg  <= '0;
                    peak_reg <= '0;
                    pidx_reg <= '0;
                    seq_reg  <= seq_reg + 16'd1;
                end else begin
                    cnt_reg  <= cnt_next;
                    sum_reg  <= sum_next;
                    peak_reg <= peak_next;
                    pidx_reg <= pidx_next;
                end
            end

            case (state_reg)
                EMPTY: begin
                    if (frame_close) begin
                        state_reg    <= FULL;
                        m_tvalid_reg <= 1'b1;
                        m_tdata_reg  <= summary_next;
                    end
                end
                FULL: begin
                    // A close here implies downstream took the old summary this cycle.
                    if (frame_close) begin
                        m_tdata_reg <= summary_next;
                    end else if (m00_axis.tready) begin
                        state_reg    <= EMPTY;
                        m_tvalid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= EMPTY;
                    m_tvalid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign m00_axis.tdata  = m_tdata_reg;
    assign m00_axis.tvalid = m_tvalid_reg;
    assign m00_axis.tlast  = m_tvalid_reg;
endmodule

// File: tb/tb_axis_frame_peak.sv
// Directed plus randomized bench for axis_frame_peak against a frame-level
// reference model that rebuilds each summary from the stored beats.
module tb_axis_frame_peak;
    localparam int FL = 4096;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    axis_frame_peak_if #(.DATA_W(64))  s_if ();
    axis_frame_peak_if #(.DATA_W(128)) m_if ();

    axis_frame_peak #(
        .FRAME_LEN (FL),
        .MAG_LSB   (40),
        .MAG_W     (24)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (areset),
        .s00_axis        (s_if),
        .m00_axis        (m_if)
    );

    bit rand_mode = 1'b0;
    bit rdy_fixed = 1'b1;
    bit rnd_bit   = 1'b1;
    always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));
    assign m_if.tready = rand_mode ? rnd_bit : rdy_fixed;

    int unsigned  vectors = 0;
    int unsigned  miscompares = 0;
    int unsigned  cur_q[$];
    logic [15:0]  seq_m = 16'd0;
    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];

    always @(posedge clk) begin
        if (!areset && m_if.tvalid && m_if.tready) got_q.push_back(m_if.tdata);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: frame closes on tlast or on reaching FL beats.
    function automatic void model_accept(input int unsigned mag, input bit last);
        longint unsigned sum;
        int unsigned     pk;
        int unsigned     pi;
        int unsigned     n;
        logic [127:0]    s;
        cur_q.push_back(mag);
        if (last || cur_q.size() == FL) begin
            n = cur_q.size();
            sum = 0; pk = 0; pi = 0;
            for (int i = 0; i < int'(n); i++) begin
                sum += cur_q[i];
                if (i == 0 || cur_q[i] > pk) begin
                    pk = cur_q[i];
                    pi = i;
                end
            end
            s = '0;
            s[127:80] = sum[47:0];
            s[79:56]  = pk[23:0];
            s[55:40]  = pi[15:0];
            s[39:24]  = n[15:0];
            s[23:8]   = seq_m;
            s[1]      = !last && n == FL;
            s[0]      = last && n < FL;
            exp_q.push_back(s);
            cur_q.delete();
            seq_m++;
        end
    endfunction

    task automatic send_beat(input int unsigned mag, input bit last);
        logic [63:0] d;
        bit acc;
        int waited;
        @(negedge clk);
        d = {$urandom, $urandom};
        d[40 +: 24] = mag[23:0];
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        s_if.tlast  = last;
        acc = 1'b0;
        waited = 0;
        while (!acc) begin
            #1 acc = s_if.tready;
            @(posedge clk);
            if (!acc) begin
                waited++;
                if (waited > 200) begin
                    chk("accept_timeout", 128'(0), 128'(1));
                    break;
                end
                @(negedge clk);
            end
        end
        if (acc) model_accept(mag, last);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        while (got_q.size() < exp_q.size() && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk(tag, got_q[i], exp_q[i]);
            else chk(tag, 128'bx, exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int unsigned ties[8] = '{5, 9, 9, 3, 0, 9, 1, 2};
        int unsigned len;

        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;

        // Reset behaviour
        repeat (3) @(negedge clk);
        #1;
        chk("tready_in_reset", 128'(s_if.tready), 128'(0));
        chk("tvalid_in_reset", 128'(m_if.tvalid), 128'(0));
        @(negedge clk);
        areset = 1'b0;
        #1;
        chk("tready_after_reset", 128'(s_if.tready), 128'(1));
        chk("tvalid_after_reset", 128'(m_if.tvalid), 128'(0));
        chk("tlast_after_reset", 128'(m_if.tlast), 128'(0));
        chk("tdata_after_reset", m_if.tdata, 128'(0));

        // Ramp frame: full length with tlast on the final beat
        for (int i = 0; i < FL; i++) send_beat(i, i == FL - 1);
        #1;
        chk("ramp_latency_valid", 128'(m_if.tvalid), 128'(1));
        chk("ramp_tlast", 128'(m_if.tlast), 128'(1));
        wait_drain();
        chk("ramp_sum", 128'(got_q[0][127:80]), 128'(8386560));
        chk("ramp_peak", 128'(got_q[0][79:56]), 128'(4095));
        chk("ramp_pidx", 128'(got_q[0][55:40]), 128'(4095));
        chk("ramp_cnt", 128'(got_q[0][39:24]), 128'(4096));
        chk("ramp_seq", 128'(got_q[0][23:8]), 128'(0));
        chk("ramp_flags", 128'(got_q[0][7:0]), 128'(0));
        compare_all("ramp");

        // Ties: first occurrence of the maximum wins
        for (int i = 0; i < 8; i++) send_beat(ties[i], i == 7);
        wait_drain();
        chk("ties_sum", 128'(got_q[0][127:80]), 128'(38));
        chk("ties_peak", 128'(got_q[0][79:56]), 128'(9));
        chk("ties_pidx", 128'(got_q[0][55:40]), 128'(1));
        chk("ties_cnt", 128'(got_q[0][39:24]), 128'(8));
        chk("ties_flags", 128'(got_q[0][7:0]), 128'(1));
        compare_all("ties");

        // Missing tlast: force close at FL, remainder starts a new frame
        for (int i = 0; i < FL + 4; i++) send_beat(24'hFFFFFF, 1'b0);
        send_beat(0, 1'b1);
        wait_drain();
        chk("long_cnt", 128'(got_q[0][39:24]), 128'(4096));
        chk("long_sum", 128'(got_q[0][127:80]), 128'(36'hFFFFFF000));
        chk("long_flags", 128'(got_q[0][7:0]), 128'(2));
        chk("long_rest_cnt", 128'(got_q[1][39:24]), 128'(5));
        compare_all("long");

        // Backpressure over two 2-beat frames
        @(negedge clk);
        rdy_fixed = 1'b0;
        send_beat(11, 1'b0);
        send_beat(22, 1'b1);
        #1;
        chk("bp_first_valid", 128'(m_if.tvalid), 128'(1));
        send_beat(33, 1'b0);
        @(negedge clk);
        s_if.tdata  = 64'(44) << 40;
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b1;
        #1;
        chk("bp_close_stalled", 128'(s_if.tready), 128'(0));
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("bp_hold_data", m_if.tdata, exp_q[0]);
            chk("bp_hold_valid", 128'(m_if.tvalid), 128'(1));
            chk("bp_still_stalled", 128'(s_if.tready), 128'(0));
        end
        @(negedge clk);
        rdy_fixed = 1'b1;
        #1;
        chk("bp_close_released", 128'(s_if.tready), 128'(1));
        @(posedge clk);
        model_accept(44, 1'b1);
        wait_drain();
        compare_all("bp");

        // Back-to-back single-beat frames
        for (int i = 0; i < 20; i++) begin
            send_beat($urandom_range(0, 24'hFFFFFF), 1'b1);
            #1;
            chk("b2b_valid", 128'(m_if.tvalid), 128'(1));
        end
        wait_drain();
        compare_all("b2b");

        // Reset with a pending summary and a partial frame
        @(negedge clk);
        rdy_fixed = 1'b0;
        send_beat(7, 1'b0);
        send_beat(8, 1'b1);
        send_beat(100, 1'b0);
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        areset = 1'b1;
        #1;
        chk("rst_tready_low", 128'(s_if.tready), 128'(0));
        @(negedge clk);
        areset = 1'b0;
        #1;
        chk("rst_tvalid_cleared", 128'(m_if.tvalid), 128'(0));
        chk("rst_no_output", 128'(got_q.size()), 128'(0));
        exp_q.delete();
        cur_q.delete();
        seq_m = 16'd0;
        rdy_fixed = 1'b1;
        send_beat(3, 1'b0);
        send_beat(1, 1'b0);
        send_beat(2, 1'b1);
        wait_drain();
        chk("rst_seq_zero", 128'(got_q[0][23:8]), 128'(0));
        chk("rst_sum", 128'(got_q[0][127:80]), 128'(6));
        compare_all("rst");

        // Randomized frames with random downstream backpressure and gaps
        rand_mode = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 10);
            for (int b = 0; b < int'(len); b++) begin
                send_beat($urandom_range(0, 24'hFFFFFF), b == int'(len) - 1);
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    s_if.tvalid = 1'b0;
                end
            end
        end
        rand_mode = 1'b0;
        wait_drain();
        compare_all("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
